cmd_updown_counter: RTL

CMD_UPDOWN_COUNTER -- requirements
Module: cmd_updown_counter

---
 rtl/counter_pkg.sv | 22 ++
 rtl/tick_divider.sv | 26 ++
 rtl/cmd_updown_counter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared command bytes, status bytes and FSM state encoding for the UART-driven
// up/down counter.
package counter_pkg;

  localparam logic [7:0] CMD_RUN    = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STOP   = 8'h53;  // 'S'
  localparam logic [7:0] CMD_CLEAR  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_MODE   = 8'h4D;  // 'M'
  localparam logic [7:0] CMD_UP     = 8'h55;  // 'U'
  localparam logic [7:0] CMD_DOWN   = 8'h44;  // 'D'
  localparam logic [7:0] CMD_STATUS = 8'h3F;  // '?'

  localparam logic [7:0] STAT_RUN  = 8'h52;
  localparam logic [7:0] STAT_STOP = 8'h53;

  typedef enum logic [1:0] {STOP, RUN, CLEAR} state_t;

  function automatic logic [7:0] status_byte(input logic run);
    return run ? STAT_RUN : STAT_STOP;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running step divider: tick is high on the enabled cycle where the
// divider sits at TICK_DIV-1; clr has priority and zeroes the divider.
module tick_divider #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] div;

  assign tick = en && (div == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      div <= '0;
    else if (clr)   div <= '0;
    else if (en)    div <= tick ? '0 : div + DW'(1);
  end

endmodule

// File: rtl/cmd_updown_counter.sv
// Command-byte controlled up/down counter with status responses over a
// one-entry transmit register. Define CMD_COUNTER_ECHO_EN to echo every byte.
module cmd_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 14,
  parameter int MAX_COUNT = 9999,
  parameter int TICK_DIV  = 10_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             mode_down,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAXC = WIDTH'(MAX_COUNT);

  state_t state, state_nx;
  logic   resume_run, resume_nx;
  logic   step;
  logic   pending;
  logic [7:0] pend_byte;

  logic cmd_run, cmd_stop, cmd_clear, cmd_mode, cmd_up, cmd_down, cmd_status;
  assign cmd_run    = rx_done && (rx_data == CMD_RUN);
  assign cmd_stop   = rx_done && (rx_data == CMD_STOP);
  assign cmd_clear  = rx_done && (rx_data == CMD_CLEAR);
  assign cmd_mode   = rx_done && (rx_data == CMD_MODE);
  assign cmd_up     = rx_done && (rx_data == CMD_UP);
  assign cmd_down   = rx_done && (rx_data == CMD_DOWN);
  assign cmd_status = rx_done && (rx_data == CMD_STATUS);

  // CLEAR is transparent to the run/stop view: running keeps the held state.
  assign running = (state == RUN) || (state == CLEAR && resume_run);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= STOP;
      resume_run <= 1'b0;
    end else begin
      state      <= state_nx;
      resume_run <= resume_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    resume_nx = resume_run;
    case (state)
      STOP:    if (cmd_run)  state_nx = RUN;
      RUN:     if (cmd_stop) state_nx = STOP;
      CLEAR: begin
        if (cmd_run)       state_nx = RUN;
        else if (cmd_stop) state_nx = STOP;
        else               state_nx = resume_run ? RUN : STOP;
      end
      default: state_nx = STOP;
    endcase
    if (cmd_clear) begin
      state_nx  = CLEAR;
      resume_nx = running;
    end
  end

  tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .en    (state == RUN),
    .clr   (cmd_clear),
    .tick  (step)
  );

  // The step uses the registered mode, so a coincident mode command applies
  // from the following step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      wrap      <= 1'b0;
      mode_down <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (cmd_clear) begin
        count <= '0;
      end else if (step) begin
        if (!mode_down) begin
          if (count == MAXC) begin
            count <= '0;
            wrap  <= 1'b1;
          end else begin
            count <= count + WIDTH'(1);
          end
        end else begin
          if (count == '0) begin
            count <= MAXC;
            wrap  <= 1'b1;
          end else begin
            count <= count - WIDTH'(1);
          end
        end
      end
      if (cmd_mode)      mode_down <= !mode_down;
      else if (cmd_up)   mode_down <= 1'b0;
      else if (cmd_down) mode_down <= 1'b1;
    end
  end

  assign tx_start = pending && !tx_busy;
  assign tx_data  = pend_byte;

  // Later writes in this block override earlier ones: latest response wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= 1'b0;
      pend_byte <= 8'h00;
    end else begin
      if (tx_start) pending <= 1'b0;
`ifdef CMD_COUNTER_ECHO_EN
      if (rx_done) begin
        pending   <= 1'b1;
        pend_byte <= rx_data;
      end
`else
`endif
      if (cmd_status) begin
        pending   <= 1'b1;
        pend_byte <= status_byte(running);
      end
    end
  end

endmodule
